// File: rtl/phase_recovery_rx_if.sv
// phase_recovery_rx_if: received symbol stream in, lock/phase/error status out.
interface phase_recovery_rx_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       locked;
   logic [7:0] phase;
   logic       phase_valid;
   logic       lock_lost;
   logic [7:0] err_count;
   modport master (
      output in_valid, in_data,
      input  locked, phase, phase_valid, lock_lost, err_count
   );
   modport slave (
      input  in_valid, in_data,
      output locked, phase, phase_valid, lock_lost, err_count
   );
endinterface

// File: rtl/phase_recovery_rx.sv
// phase_recovery_rx: finds the LOW,LOW,LOW,MID signature of the phase-coded source,
// rebuilds its 8-bit counter and tracks it, reporting lock, phase and mismatches.
module phase_recovery_rx #(
   parameter logic [7:0] VAL_LOW     = 8'd10,
   parameter logic [7:0] VAL_MID     = 8'd20,
   parameter logic [7:0] VAL_HIGH    = 8'd30,
   parameter int         CONFIRM_N   = 4,
   parameter int         LOSS_THRESH = 4
) (
   input logic             clock,
   input logic             reset_n,
   phase_recovery_rx_if.slave bus
);
   typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_t;
   state_t     state_q, state_d;
   logic [2:0] run_q, run_d;
   logic [7:0] pred_q, pred_d;
   logic [3:0] conf_q, conf_d;
   logic [3:0] miss_q, miss_d;
   logic [7:0] phase_q, phase_d;
   logic [7:0] err_q, err_d;
   logic       phase_valid_q, phase_valid_d;
   logic       lock_lost_q, lock_lost_d;
   logic [7:0] exp_sym;
   logic       hit;
   assign exp_sym = pred_q <= 8'd2 ? VAL_LOW : pred_q == 8'd3 ? VAL_MID : VAL_HIGH;
   assign hit     = bus.in_data == exp_sym;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= HUNT;
         run_q         <= '0;
         pred_q        <= '0;
         conf_q        <= '0;
         miss_q        <= '0;
         phase_q       <= '0;
         err_q         <= '0;
         phase_valid_q <= 1'b0;
         lock_lost_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         run_q         <= run_d;
         pred_q        <= pred_d;
         conf_q        <= conf_d;
         miss_q        <= miss_d;
         phase_q       <= phase_d;
         err_q         <= err_d;
         phase_valid_q <= phase_valid_d;
         lock_lost_q   <= lock_lost_d;
      end
   end
   always_comb begin
      state_d       = state_q;
      run_d         = run_q;
      pred_d        = pred_q;
      conf_d        = conf_q;
      miss_d        = miss_q;
      phase_d       = phase_q;
      err_d         = err_q;
      phase_valid_d = 1'b0;
      lock_lost_d   = 1'b0;
      if (bus.in_valid) begin
         case (state_q)
            HUNT: begin
               // only a run of exactly three lows before MID is a genuine sync
               if (bus.in_data == VAL_LOW)
                  run_d = run_q == 3'd4 ? 3'd4 : run_q + 3'd1;
               else if (bus.in_data == VAL_MID && run_q == 3'd3) begin
                  state_d = CONFIRM;
                  pred_d  = 8'd4;
                  conf_d  = '0;
               end else
                  run_d = '0;
            end
            CONFIRM: begin
               if (hit) begin
                  pred_d = pred_q + 8'd1;
                  conf_d = conf_q + 4'd1;
                  if (conf_q + 4'd1 == 4'(CONFIRM_N)) begin
                     state_d       = LOCKED;
                     phase_d       = pred_q;
                     phase_valid_d = 1'b1;
                     miss_d        = '0;
                  end
               end else begin
                  state_d = HUNT;
                  run_d   = {2'b00, bus.in_data == VAL_LOW};
               end
            end
            LOCKED: begin
               // flywheel: phase follows the prediction even on mismatches
               phase_d       = pred_q;
               pred_d        = pred_q + 8'd1;
               phase_valid_d = 1'b1;
               if (hit)
                  miss_d = '0;
               else begin
                  miss_d = miss_q + 4'd1;
                  err_d  = err_q == 8'hff ? err_q : err_q + 8'd1;
                  if (miss_q + 4'd1 == 4'(LOSS_THRESH)) begin
                     state_d     = HUNT;
                     lock_lost_d = 1'b1;
                     run_d       = '0;
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end
   assign bus.locked      = state_q == LOCKED;
   assign bus.phase       = phase_q;
   assign bus.phase_valid = phase_valid_q;
   assign bus.lock_lost   = lock_lost_q;
   assign bus.err_count   = err_q;
endmodule
